turbo_pop_merge: RTL and testbench

TURBO_POP_MERGE -- requirements
Module: Turbo_Pop_Merge

---
 rtl/turbo_pop_merge_pkg.sv | 24 ++
 rtl/turbo_lane_fifo.sv | 57 +++++
 rtl/turbo_pop_merge.sv | 94 +++++++++
 tb/tb_turbo_pop_merge.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/turbo_pop_merge_pkg.sv
// Shared Turbo definitions: word-width helper, priority compare and merge FSM states.
// The priority compare is widened to MAX_PTW so it can serve any lane width up to that.
package turbo_pop_merge_pkg;

  localparam int PTW_DEF   = 16;
  localparam int MTW_DEF   = 32;
  localparam int DEPTH_DEF = 4;
  localparam int MAX_PTW   = 64;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } merge_st_t;

  function automatic int word_width(input int mtw, input int ptw);
    return mtw + ptw;
  endfunction

  // Unsigned priority compare; a tie favours the first operand (lane 0).
  function automatic logic prio_le(input logic [MAX_PTW-1:0] a, input logic [MAX_PTW-1:0] b);
    return a <= b;
  endfunction

endpackage

// File: rtl/turbo_lane_fifo.sv
// Per-lane result FIFO; registered head, a write to a full lane is accepted only alongside a read.
// Unaccepted writes to a full lane pulse drop for the parent's sticky overflow flag.
module turbo_lane_fifo #(
  parameter int DW    = 48,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_data,
  input  logic                     rd_en,
  output logic [DW-1:0]            rd_data,
  output logic                     empty,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          rd_ok;
  logic          wr_ok;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && !flush && (!full || rd_ok);
  assign drop    = wr_en && !flush && full && !rd_ok;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_ok);
      rd_ptr <= rd_ptr + AW'(rd_ok);
      level  <= level + LW'(wr_ok) - LW'(rd_ok);
    end
  end

endmodule

// File: rtl/turbo_pop_merge.sv
// Merges two unstallable pop-result pipelines into one minimum-priority stream; one cycle from lane write to output.
// Output holds under i_ready low; lanes buffer DEPTH words each, further writes drop and set sticky overflow.
module turbo_pop_merge
  import turbo_pop_merge_pkg::*;
#(
  parameter int PTW   = PTW_DEF,
  parameter int MTW   = MTW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_arst_n,
  input  logic                   i_p0_valid,
  input  logic [MTW+PTW-1:0]     i_p0_data,
  input  logic                   i_p1_valid,
  input  logic [MTW+PTW-1:0]     i_p1_data,
  input  logic                   i_flush,
  output logic                   o_valid,
  output logic [MTW+PTW-1:0]     o_data,
  input  logic                   i_ready,
  output logic                   o_overflow,
  output logic [$clog2(DEPTH):0] o_p0_level,
  output logic [$clog2(DEPTH):0] o_p1_level
);

  localparam int DW = word_width(MTW, PTW);

  merge_st_t     state;
  logic [DW-1:0] head0;
  logic [DW-1:0] head1;
  logic          empty0;
  logic          empty1;
  logic          drop0;
  logic          drop1;
  logic          load;
  logic          sel0;
  logic          pop0;
  logic          pop1;

  assign load = ((state == ST_EMPTY) || i_ready) && (!empty0 || !empty1);
  assign sel0 = !empty0 && (empty1 ||
                prio_le(MAX_PTW'(head0[PTW-1:0]), MAX_PTW'(head1[PTW-1:0])));
  assign pop0 = load && sel0;
  assign pop1 = load && !sel0;

  turbo_lane_fifo #(.DW(DW), .DEPTH(DEPTH)) u_lane0 (
    .clk     (i_clk),
    .arst_n  (i_arst_n),
    .flush   (i_flush),
    .wr_en   (i_p0_valid),
    .wr_data (i_p0_data),
    .rd_en   (pop0),
    .rd_data (head0),
    .empty   (empty0),
    .drop    (drop0),
    .level   (o_p0_level)
  );

  turbo_lane_fifo #(.DW(DW), .DEPTH(DEPTH)) u_lane1 (
    .clk     (i_clk),
    .arst_n  (i_arst_n),
    .flush   (i_flush),
    .wr_en   (i_p1_valid),
    .wr_data (i_p1_data),
    .rd_en   (pop1),
    .rd_data (head1),
    .empty   (empty1),
    .drop    (drop1),
    .level   (o_p1_level)
  );

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state      <= ST_EMPTY;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_overflow <= 1'b0;
    end else if (i_flush) begin
      state      <= ST_EMPTY;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (drop0 || drop1) o_overflow <= 1'b1;
      if (load) begin
        state   <= ST_HOLD;
        o_valid <= 1'b1;
        o_data  <= sel0 ? head0 : head1;
      end else if (state == ST_HOLD && i_ready) begin
        state   <= ST_EMPTY;
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_turbo_pop_merge.sv
// Directed bench for turbo_pop_merge (PTW=16, MTW=32, DEPTH=4).
module tb_turbo_pop_merge;

  localparam int PTW = 16;
  localparam int MTW = 32;
  localparam int DW  = MTW + PTW;

  logic          i_clk = 1'b0;
  logic          i_arst_n = 1'b0;
  logic          i_p0_valid = 1'b0;
  logic [DW-1:0] i_p0_data = '0;
  logic          i_p1_valid = 1'b0;
  logic [DW-1:0] i_p1_data = '0;
  logic          i_flush = 1'b0;
  logic          i_ready = 1'b1;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          o_overflow;
  logic [2:0]    o_p0_level;
  logic [2:0]    o_p1_level;

  int vectors = 0;
  int errors  = 0;

  turbo_pop_merge #(.PTW(PTW), .MTW(MTW), .DEPTH(4)) dut (
    .i_clk      (i_clk),
    .i_arst_n   (i_arst_n),
    .i_p0_valid (i_p0_valid),
    .i_p0_data  (i_p0_data),
    .i_p1_valid (i_p1_valid),
    .i_p1_data  (i_p1_data),
    .i_flush    (i_flush),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .i_ready    (i_ready),
    .o_overflow (o_overflow),
    .o_p0_level (o_p0_level),
    .o_p1_level (o_p1_level)
  );

  initial forever #5 i_clk = ~i_clk;

  function automatic logic [DW-1:0] mk(input int meta, input int prio);
    logic [MTW-1:0] m;
    logic [PTW-1:0] p;
    m = MTW'(meta);
    p = PTW'(prio);
    return {m, p};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if (o_valid !== 1'b0 || o_data !== '0 || o_overflow !== 1'b0 ||
        o_p0_level !== 3'd0 || o_p1_level !== 3'd0) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h ovf=%b l0=%0d l1=%0d, want all zero",
               o_valid, o_data, o_overflow, o_p0_level, o_p1_level);
    end
    tick();
    i_arst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    i_p0_valid = 1'b1; i_p0_data = mk(32'h11, 7);
    tick();
    i_p0_valid = 1'b0;
    vectors++;
    if (o_valid !== 1'b0 || o_p0_level !== 3'd1) begin
      errors++;
      $display("FAIL single_edge0: valid=%b l0=%0d, want 0/1", o_valid, o_p0_level);
    end
    tick();
    vectors++;
    if (o_valid !== 1'b1 || o_data !== mk(32'h11, 7) || o_p0_level !== 3'd0) begin
      errors++;
      $display("FAIL single_edge1: valid=%b data=%h l0=%0d, want 1/%h/0",
               o_valid, o_data, o_p0_level, mk(32'h11, 7));
    end
    tick();
    vectors++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_edge2: valid=%b, want 0", o_valid);
    end
  endtask

  task automatic test_merge();
    i_p0_valid = 1'b1; i_p0_data = mk(1, 9);
    i_p1_valid = 1'b1; i_p1_data = mk(2, 3);
    tick();
    i_p0_valid = 1'b0; i_p1_valid = 1'b0;
    tick();
    vectors++;
    if (o_valid !== 1'b1 || o_data !== mk(2, 3)) begin
      errors++;
      $display("FAIL merge_first: valid=%b data=%h, want 1/%h", o_valid, o_data, mk(2, 3));
    end
    tick();
    vectors++;
    if (o_valid !== 1'b1 || o_data !== mk(1, 9)) begin
      errors++;
      $display("FAIL merge_second: valid=%b data=%h, want 1/%h", o_valid, o_data, mk(1, 9));
    end
    i_p1_valid = 1'b1; i_p1_data = mk(3, 2);
    tick();
    i_p1_valid = 1'b0;
    vectors++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL merge_drain: valid=%b, want 0", o_valid);
    end
    tick();
    vectors++;
    if (o_valid !== 1'b1 || o_data !== mk(3, 2)) begin
      errors++;
      $display("FAIL lane1_only: valid=%b data=%h, want 1/%h", o_valid, o_data, mk(3, 2));
    end
    tick();
  endtask

  task automatic test_tie();
    i_p0_valid = 1'b1; i_p0_data = mk(32'hA, 5);
    i_p1_valid = 1'b1; i_p1_data = mk(32'hB, 5);
    tick();
    i_p0_valid = 1'b0; i_p1_valid = 1'b0;
    tick();
    vectors++;
    if (o_valid !== 1'b1 || o_data[PTW +: MTW] !== 32'hA) begin
      errors++;
      $display("FAIL tie_first: valid=%b meta=%h, want 1/a", o_valid, o_data[PTW +: MTW]);
    end
    tick();
    vectors++;
    if (o_valid !== 1'b1 || o_data[PTW +: MTW] !== 32'hB) begin
      errors++;
      $display("FAIL tie_second: valid=%b meta=%h, want 1/b", o_valid, o_data[PTW +: MTW]);
    end
    tick();
  endtask

  task automatic test_overflow();
    i_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      i_p0_valid = 1'b1; i_p0_data = mk(i, i);
      tick();
    end
    i_p0_valid = 1'b0;
    vectors++;
    if (o_valid !== 1'b1 || o_data !== mk(1, 1) || o_p0_level !== 3'd4 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full: valid=%b data=%h l0=%0d ovf=%b, want 1/%h/4/0",
               o_valid, o_data, o_p0_level, o_overflow, mk(1, 1));
    end
    i_p0_valid = 1'b1; i_p0_data = mk(6, 6);
    tick();
    i_p0_valid = 1'b0;
    vectors++;
    if (o_overflow !== 1'b1 || o_data !== mk(1, 1) || o_p0_level !== 3'd4) begin
      errors++;
      $display("FAIL ovf_drop: ovf=%b data=%h l0=%0d, want 1/%h/4",
               o_overflow, o_data, o_p0_level, mk(1, 1));
    end
  endtask

  task automatic test_flush();
    i_flush = 1'b1;
    i_p1_valid = 1'b1; i_p1_data = mk(9, 9);
    tick();
    i_flush = 1'b0; i_p1_valid = 1'b0;
    vectors++;
    if (o_valid !== 1'b0 || o_p0_level !== 3'd0 || o_p1_level !== 3'd0 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL flush: valid=%b l0=%0d l1=%0d ovf=%b, want 0/0/0/0",
               o_valid, o_p0_level, o_p1_level, o_overflow);
    end
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (o_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_quiet[%0d]: valid=%b, want 0", i, o_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b0;
    for (int i = 11; i <= 15; i++) begin
      i_p0_valid = 1'b1; i_p0_data = mk(i, i);
      tick();
    end
    i_ready = 1'b1;
    i_p0_valid = 1'b1; i_p0_data = mk(16, 16);
    tick();
    i_p0_valid = 1'b0;
    vectors++;
    if (o_p0_level !== 3'd4 || o_overflow !== 1'b0 || o_data !== mk(12, 12)) begin
      errors++;
      $display("FAIL full_read: l0=%0d ovf=%b data=%h, want 4/0/%h",
               o_p0_level, o_overflow, o_data, mk(12, 12));
    end
    for (int i = 13; i <= 16; i++) begin
      tick();
      vectors++;
      if (o_valid !== 1'b1 || o_data !== mk(i, i)) begin
        errors++;
        $display("FAIL b2b[%0d]: valid=%b data=%h, want 1/%h", i, o_valid, o_data, mk(i, i));
      end
    end
    tick();
    vectors++;
    if (o_valid !== 1'b0 || o_p0_level !== 3'd0) begin
      errors++;
      $display("FAIL b2b_end: valid=%b l0=%0d, want 0/0", o_valid, o_p0_level);
    end
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      i_p0_valid = 1'b1; i_p0_data = mk(i, 20 + i);
      tick();
    end
    i_p0_valid = 1'b0;
    #2;
    i_arst_n = 1'b0;
    #1;
    vectors++;
    if (o_valid !== 1'b0 || o_data !== '0 || o_p0_level !== 3'd0) begin
      errors++;
      $display("FAIL arst_async: valid=%b data=%h l0=%0d, want 0/0/0", o_valid, o_data, o_p0_level);
    end
    tick();
    i_arst_n = 1'b1;
    i_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (o_valid !== 1'b0) begin
        errors++;
        $display("FAIL arst_quiet[%0d]: valid=%b, want 0", i, o_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_merge();
    test_tie();
    test_overflow();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
